// File: rtl/modbus_rtu_framer_pkg.sv
// Shared types and constants for the Modbus RTU frame delimiter.
// Latency: none (types, constants and elaboration-time helpers only).
// Backpressure: none.
// Contents: framer_fsm_t state type, broadcast address, length-counter width,
//           minimum legal frame length, and t1.5/t3.5 cycle calculators.
package modbus_rtu_framer_pkg;

   // Unit address 0 is a broadcast: every slave accepts it and none replies.
   localparam logic [7:0] BROADCAST_ADDR = 8'h00;

   // Frame length counter width; holds 0..256 (address + PDU + CRC).
   localparam int LEN_W = 9;

   // Smallest well-formed frame: address + function code + CRC16.
   localparam int MIN_FRAME_LEN = 4;

   typedef enum logic [1:0] {
      SYNC_S = 2'd0,
      IDLE_S = 2'd1,
      RECV_S = 2'd2,
      DROP_S = 2'd3
   } framer_fsm_t;

   // Above 19200 baud the inter-character timings are fixed at 750 us / 1750 us;
   // at or below it they scale with the character time (11 bits per character).
   // 64-bit arithmetic because CLK_HZ*1750 overflows 32 bits at 50 MHz.
   function automatic int calc_t15(input longint clk_hz, input longint baud);
      longint cyc;
      if (baud > 64'sd19200) cyc = (clk_hz * 750) / 1000000;
      else                   cyc = (clk_hz * 165) / (10 * baud);
      return int'(cyc);
   endfunction

   function automatic int calc_t35(input longint clk_hz, input longint baud);
      longint cyc;
      if (baud > 64'sd19200) cyc = (clk_hz * 1750) / 1000000;
      else                   cyc = (clk_hz * 385) / (10 * baud);
      return int'(cyc);
   endfunction

endpackage

// File: rtl/modbus_silence_timer.sv
// Line-silence timer: counts clocks since the last received byte, saturating at t3.5.
// Latency: flags are combinational from the registered count (t35_reached looks one edge ahead).
// Backpressure: none; restarts on every rx_valid strobe.
// Ports: clk, rst (async, active-high), rx_valid (byte strobe) ->
//        t15_exceeded (gap since last byte is beyond t1.5),
//        t35_reached  (count arrives at t3.5 on the coming edge with no byte this cycle).
module modbus_silence_timer #(
   parameter int T15_CYC = 750,
   parameter int T35_CYC = 1750
) (
   input  logic clk,
   input  logic rst,
   input  logic rx_valid,
   output logic t15_exceeded,
   output logic t35_reached
);

   localparam int CNT_W = $clog2(T35_CYC + 1);
   localparam logic [CNT_W-1:0] T15_L    = CNT_W'(T15_CYC);
   localparam logic [CNT_W-1:0] T35_L    = CNT_W'(T35_CYC);
   localparam logic [CNT_W-1:0] T35_M1_L = CNT_W'(T35_CYC - 1);

   logic [CNT_W-1:0] sil_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sil_cnt <= '0;
      end else if (rx_valid) begin
         sil_cnt <= '0;
      end else if (sil_cnt != T35_L) begin
         sil_cnt <= sil_cnt + CNT_W'(1);
      end
   end

   // Sampled in the cycle a byte arrives, sil_cnt is exactly the gap before it.
   assign t15_exceeded = (sil_cnt > T15_L);

   // Raised one cycle early so the registered frm_eof lands in the same cycle
   // that sil_cnt shows T35_CYC. The >= also covers an already-saturated count.
   assign t35_reached = !rx_valid && (sil_cnt >= T35_M1_L);

endmodule

// File: rtl/modbus_rtu_framer.sv
// Modbus RTU frame delimiter: splits the UART byte stream on line silence, filters on
//   unit address, strips the address and forwards function code, payload and CRC.
// Latency: frm_valid/frm_data one cycle after rx_valid; frm_eof when silence reaches t3.5
//   (or the cycle after a byte that breaks the frame). Backpressure: none, one byte per rx_valid.
// Ports: clk, rst (async active-high); rx_byte/rx_valid/rx_err from UART;
//   frm_data/frm_valid/frm_sof/frm_eof/frm_err/frm_bcast to the slave RX FSM; busy = not idle.
module modbus_rtu_framer
   import modbus_rtu_framer_pkg::*;
#(
   parameter int         CLK_HZ     = 50_000_000,
   parameter int         BAUD       = 115200,
   parameter logic [7:0] SLAVE_ADDR = 8'h01,
   parameter int         MAX_LEN    = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic [7:0] frm_data,
   output logic       frm_valid,
   output logic       frm_sof,
   output logic       frm_eof,
   output logic       frm_err,
   output logic       frm_bcast,
   output logic       busy
);

   localparam int T15_CYC = calc_t15(longint'(CLK_HZ), longint'(BAUD));
   localparam int T35_CYC = calc_t35(longint'(CLK_HZ), longint'(BAUD));

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_FRAME_LEN);
   localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

   framer_fsm_t      state;
   logic [LEN_W-1:0] len_cnt;
   logic             t15_exceeded;
   logic             t35_reached;
   logic             run_q;
   logic             addr_hit;
   logic             sof_done;

   modbus_silence_timer #(
      .T15_CYC (T15_CYC),
      .T35_CYC (T35_CYC)
   ) u_silence_timer (
      .clk          (clk),
      .rst          (rst),
      .rx_valid     (rx_valid),
      .t15_exceeded (t15_exceeded),
      .t35_reached  (t35_reached)
   );

   assign addr_hit = (rx_byte == SLAVE_ADDR) || (rx_byte == BROADCAST_ADDR);

   // len_cnt counts the address too, so anything above 1 means sof went out
   // and the consumer is owed exactly one frm_eof.
   assign sof_done = (len_cnt > ONE_L);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SYNC_S;
         len_cnt   <= '0;
         frm_data  <= '0;
         frm_valid <= 1'b0;
         frm_sof   <= 1'b0;
         frm_eof   <= 1'b0;
         frm_err   <= 1'b0;
         frm_bcast <= 1'b0;
      end else begin
         frm_valid <= 1'b0;
         frm_sof   <= 1'b0;
         frm_eof   <= 1'b0;
         frm_err   <= 1'b0;
         // bcast lives until the cycle after eof; a new broadcast address
         // accepted in that same cycle (IDLE_S below) takes precedence.
         if (frm_eof) frm_bcast <= 1'b0;

         case (state)
            // After reset we may have woken mid-frame: wait for a full t3.5 of quiet.
            SYNC_S: begin
               if (t35_reached) state <= IDLE_S;
            end

            IDLE_S: begin
               len_cnt <= '0;
               if (rx_valid) begin
                  if (!rx_err && addr_hit) begin
                     state     <= RECV_S;
                     len_cnt   <= ONE_L;
                     frm_bcast <= (rx_byte == BROADCAST_ADDR);
                  end else begin
                     state <= DROP_S;
                  end
               end
            end

            RECV_S: begin
               // A byte in this cycle always beats the silence-based close.
               if (rx_valid) begin
                  if (!t15_exceeded && !rx_err && (len_cnt < MAX_LEN_L)) begin
                     frm_valid <= 1'b1;
                     frm_data  <= rx_byte;
                     frm_sof   <= (len_cnt == ONE_L);
                     len_cnt   <= len_cnt + ONE_L;
                  end else begin
                     state <= DROP_S;
                     if (sof_done) begin
                        frm_eof <= 1'b1;
                        frm_err <= 1'b1;
                     end else begin
                        frm_bcast <= 1'b0;
                     end
                  end
               end else if (t35_reached) begin
                  state <= IDLE_S;
                  if (sof_done) begin
                     frm_eof <= 1'b1;
                     frm_err <= (len_cnt < MIN_LEN_L);
                  end else begin
                     // Address alone then silence: nothing was announced downstream.
                     frm_bcast <= 1'b0;
                  end
               end
            end

            DROP_S: begin
               if (t35_reached) state <= IDLE_S;
            end

            default: state <= SYNC_S;
         endcase
      end
   end

   // run_q keeps busy low while reset is held even though the FSM sits in SYNC_S.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) run_q <= 1'b0;
      else     run_q <= 1'b1;
   end

   assign busy = run_q && (state != IDLE_S);

endmodule

// File: tb/tb_modbus_rtu_framer.sv
// Self-checking bench for modbus_rtu_framer at 1 MHz / 115200 baud (t1.5=750, t3.5=1750 clocks).
// Latency: n/a. Backpressure: n/a.
// Table of directed frames with hand-derived expectations, hand sequences, random frames vs a reference model.
module tb_modbus_rtu_framer;

   localparam int CLK_PER = 10;
   localparam int T15     = 750;
   localparam int T35     = 1750;
   localparam int MAXL    = 256;
   localparam int SETTLE  = 1760;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_err = 1'b0;
   logic [7:0] frm_data;
   logic       frm_valid, frm_sof, frm_eof, frm_err, frm_bcast, busy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit         is_eof;
      logic [7:0] dat;
      bit         sof;
      bit         err;
      bit         bcast;
      time        t;
   } ev_t;

   typedef struct {
      logic [63:0] bytes;   // byte 0 in the top octet
      int          n;
      int          idle;
      int          odd_idx;
      int          odd_idle;
      int          err_idx;
      int          exp_fwd;
      int          exp_eof;
      bit          exp_err;
      bit          exp_bcast;
   } vec_t;

   ev_t got[$];
   ev_t exp_q[$];
   bit  prev_eof = 1'b0;
   time samp_t = 0;

   always #5 clk = ~clk;

   modbus_rtu_framer #(
      .CLK_HZ     (1_000_000),
      .BAUD       (115200),
      .SLAVE_ADDR (8'h01),
      .MAX_LEN    (MAXL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .rx_err    (rx_err),
      .frm_data  (frm_data),
      .frm_valid (frm_valid),
      .frm_sof   (frm_sof),
      .frm_eof   (frm_eof),
      .frm_err   (frm_err),
      .frm_bcast (frm_bcast),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Output capture, sampled on the falling edge; t is the rising edge that produced it.
   always @(negedge clk) begin
      if (rst) begin
         prev_eof = 1'b0;
      end else begin
         if (prev_eof) chk("bcast_clear_after_eof", 64'(frm_bcast), 64'd0);
         if (frm_eof)  chk("eof_not_with_valid", 64'(frm_valid), 64'd0);
         if (frm_valid) got.push_back('{1'b0, frm_data, frm_sof, 1'b0, frm_bcast, $time - 5});
         if (frm_eof)   got.push_back('{1'b1, 8'h00, 1'b0, frm_err, frm_bcast, $time - 5});
         prev_eof = frm_eof;
      end
   end

   // idle = clocks of silence before this byte, which is the gap the DUT sees.
   task automatic send_byte(input logic [7:0] b, input bit e, input int idle);
      repeat (idle) @(posedge clk);
      #1;
      rx_byte  = b;
      rx_err   = e;
      rx_valid = 1'b1;
      @(posedge clk);
      samp_t = $time;
      #1;
      rx_valid = 1'b0;
      rx_err   = 1'b0;
   endtask

   task automatic send_vec(input vec_t v);
      for (int i = 0; i < v.n; i++) begin
         int idle;
         idle = (i == 0) ? 0 : ((i == v.odd_idx) ? v.odd_idle : v.idle);
         send_byte(v.bytes[63-8*i -: 8], (i == v.err_idx), idle);
      end
   endtask

   task automatic settle();
      repeat (SETTLE) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic scan(output int nf, output int ne, output int ns, output bit l_err,
                       output bit l_bc, output time l_t, output logic [7:0] f_dat,
                       output bit f_bc, output bit f_sof);
      nf = 0; ne = 0; ns = 0; l_err = 0; l_bc = 0; l_t = 0; f_dat = 0; f_bc = 0; f_sof = 0;
      foreach (got[k]) begin
         if (got[k].is_eof) begin
            ne++;
            l_err = got[k].err;
            l_bc  = got[k].bcast;
            l_t   = got[k].t;
         end else begin
            if (nf == 0) begin
               f_dat = got[k].dat;
               f_bc  = got[k].bcast;
               f_sof = got[k].sof;
            end
            nf++;
            if (got[k].sof) ns++;
         end
      end
   endtask

   // Frame-level reference: the frame is preceded by >= t3.5 of silence, g[i] is the gap before byte i.
   task automatic model_frame(input logic [7:0] b[$], input bit e[$], input int g[$], input time ts[$]);
      int len;
      bit started;
      bit bc;
      if (e[0] || !(b[0] == 8'h01 || b[0] == 8'h00)) return;
      bc = (b[0] == 8'h00);
      len = 1;
      started = 1'b0;
      for (int i = 1; i < b.size(); i++) begin
         if (g[i] > T15 || e[i] || len >= MAXL) begin
            if (started) exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b1, bc, ts[i]});
            return;
         end
         exp_q.push_back('{1'b0, b[i], !started, 1'b0, bc, ts[i]});
         started = 1'b1;
         len++;
      end
      if (started)
         exp_q.push_back('{1'b1, 8'h00, 1'b0, (len < 4), bc, ts[b.size()-1] + time'(T35 * CLK_PER)});
   endtask

   initial begin
      vec_t       vt[14];
      int         nf, ne, ns, n, g, nmin;
      bit         l_err, l_bc, f_bc, f_sof, e;
      time        l_t, last_t;
      logic [7:0] f_dat, a, rb;
      logic [7:0] qb[$];
      bit         qe[$];
      int         qg[$];
      time        qt[$];

      //             bytes                    n  idle odd  oidle err fwd eof err bc
      vt[0]  = '{64'h0103_0000_0001_840A, 8, 100, -1,   0, -1,  7,  1, 0, 0};
      vt[1]  = '{64'h0203_0000_0001_840A, 8,  20, -1,   0, -1,  0,  0, 0, 0};
      vt[2]  = '{64'h0103_0000_0001_840A, 8,  20,  4, 800, -1,  3,  1, 1, 0};
      vt[3]  = '{64'h0103_0000_0001_840A, 8,  20, -1,   0, -1,  7,  1, 0, 0};
      vt[4]  = '{64'h0006_0001_0005_1234, 8,  20, -1,   0, -1,  7,  1, 0, 1};
      vt[5]  = '{64'h0103_0000_0000_0000, 2,  20, -1,   0, -1,  1,  1, 1, 0};
      vt[6]  = '{64'h0103_0000_0001_840A, 8,  20, -1,   0,  2,  1,  1, 1, 0};
      vt[7]  = '{64'h0103_AABB_0000_0000, 4,  20, -1,   0, -1,  3,  1, 0, 0};
      vt[8]  = '{64'h0103_1122_0000_0000, 4,  20,  2, 750, -1,  3,  1, 0, 0};
      vt[9]  = '{64'h0103_1122_0000_0000, 4,  20,  2, 751, -1,  1,  1, 1, 0};
      vt[10] = '{64'h0100_0000_0000_0000, 1,  20, -1,   0, -1,  0,  0, 0, 0};
      vt[11] = '{64'h0103_0000_0001_840A, 8,  20, -1,   0,  0,  0,  0, 0, 0};
      vt[12] = '{64'h0006_0000_0000_0000, 2,  20, -1,   0, -1,  1,  1, 1, 1};
      vt[13] = '{64'hF703_0000_0001_840A, 8,  20, -1,   0, -1,  0,  0, 0, 0};

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 64'({frm_data, frm_valid, frm_sof, frm_eof, frm_err, frm_bcast, busy}), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("sync_busy", 64'(busy), 64'd1);

      // A frame right after reset release is ignored while resynchronising.
      got.delete();
      send_vec(vt[0]);
      settle();
      scan(nf, ne, ns, l_err, l_bc, l_t, f_dat, f_bc, f_sof);
      chk("sync_fwd", 64'(nf), 64'd0);
      chk("sync_eof", 64'(ne), 64'd0);
      chk("sync_idle_busy", 64'(busy), 64'd0);

      // Directed table.
      for (int i = 0; i < 14; i++) begin
         got.delete();
         send_vec(vt[i]);
         last_t = samp_t;
         settle();
         scan(nf, ne, ns, l_err, l_bc, l_t, f_dat, f_bc, f_sof);
         chk($sformatf("v%0d_fwd", i), 64'(nf), 64'(vt[i].exp_fwd));
         chk($sformatf("v%0d_eof", i), 64'(ne), 64'(vt[i].exp_eof));
         chk($sformatf("v%0d_sof_cnt", i), 64'(ns), (vt[i].exp_fwd > 0) ? 64'd1 : 64'd0);
         if (vt[i].exp_fwd > 0) begin
            chk($sformatf("v%0d_first_dat", i), 64'(f_dat), 64'(vt[i].bytes[55:48]));
            chk($sformatf("v%0d_first_sof", i), 64'(f_sof), 64'd1);
            chk($sformatf("v%0d_first_bcast", i), 64'(f_bc), 64'(vt[i].exp_bcast));
         end
         if (vt[i].exp_eof > 0) begin
            chk($sformatf("v%0d_eof_err", i), 64'(l_err), 64'(vt[i].exp_err));
            chk($sformatf("v%0d_eof_bcast", i), 64'(l_bc), 64'(vt[i].exp_bcast));
            if (!vt[i].exp_err)
               chk($sformatf("v%0d_eof_time", i), 64'(l_t), 64'(last_t + time'(T35 * CLK_PER)));
         end
         chk($sformatf("v%0d_busy_after", i), 64'(busy), 64'd0);
      end

      // Foreign address: busy stays up until t3.5 of silence.
      got.delete();
      send_vec(vt[1]);
      repeat (1700) @(posedge clk);
      #1;
      chk("drop_busy_held", 64'(busy), 64'd1);
      repeat (60) @(posedge clk);
      #1;
      chk("drop_busy_released", 64'(busy), 64'd0);
      scan(nf, ne, ns, l_err, l_bc, l_t, f_dat, f_bc, f_sof);
      chk("drop_no_output", 64'(nf + ne), 64'd0);

      // 257-byte frame: 255 forwarded, the 257th byte overflows.
      got.delete();
      send_byte(8'h01, 1'b0, 0);
      for (int i = 1; i < 257; i++) send_byte(8'($urandom), 1'b0, 10);
      last_t = samp_t;
      settle();
      scan(nf, ne, ns, l_err, l_bc, l_t, f_dat, f_bc, f_sof);
      chk("long_fwd", 64'(nf), 64'd255);
      chk("long_eof", 64'(ne), 64'd1);
      chk("long_err", 64'(l_err), 64'd1);
      chk("long_eof_time", 64'(l_t), 64'(last_t));

      // Reset mid-frame: outputs clear at once, no eof, then resync and accept.
      got.delete();
      send_byte(8'h01, 1'b0, 0);
      send_byte(8'h03, 1'b0, 20);
      send_byte(8'h00, 1'b0, 20);
      chk("pre_rst_valid", 64'(frm_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("midrst_outputs", 64'({frm_data, frm_valid, frm_sof, frm_eof, frm_err, frm_bcast, busy}), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      settle();
      scan(nf, ne, ns, l_err, l_bc, l_t, f_dat, f_bc, f_sof);
      chk("midrst_no_eof", 64'(ne), 64'd0);
      got.delete();
      send_vec(vt[0]);
      settle();
      scan(nf, ne, ns, l_err, l_bc, l_t, f_dat, f_bc, f_sof);
      chk("post_rst_fwd", 64'(nf), 64'd7);
      chk("post_rst_eof_err", 64'({ne[1:0], l_err}), 64'b010);

      // Random frames against the reference model.
      got.delete();
      exp_q.delete();
      for (int f = 0; f < 6; f++) begin
         qb.delete(); qe.delete(); qg.delete(); qt.delete();
         n = $urandom_range(1, 8);
         case ($urandom_range(0, 4))
            0:       a = 8'h00;
            1, 2:    a = 8'h01;
            3:       a = 8'h02;
            default: a = 8'($urandom);
         endcase
         for (int i = 0; i < n; i++) begin
            rb = (i == 0) ? a : 8'($urandom);
            g  = (i == 0) ? 0 : (($urandom_range(0, 7) == 0) ? $urandom_range(760, 1200)
                                                           : $urandom_range(2, 150));
            e  = ($urandom_range(0, 11) == 0);
            send_byte(rb, e, g);
            qb.push_back(rb); qe.push_back(e); qg.push_back(g); qt.push_back(samp_t);
         end
         model_frame(qb, qe, qg, qt);
         settle();
      end
      chk("rand_event_count", 64'(got.size()), 64'(exp_q.size()));
      nmin = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int k = 0; k < nmin; k++) begin
         chk($sformatf("rand_ev%0d", k),
             64'({got[k].is_eof, got[k].dat, got[k].sof, got[k].err, got[k].bcast}),
             64'({exp_q[k].is_eof, exp_q[k].dat, exp_q[k].sof, exp_q[k].err, exp_q[k].bcast}));
         chk($sformatf("rand_ev%0d_time", k), 64'(got[k].t), 64'(exp_q[k].t));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
